// File: rtl/legv8_pkg.sv
// Shared types and constants for the LEGv8 micro-op encoder.
// Contents: op_e micro-op classes, machine opcode fields, the B.LT
// condition code, immediate range limits, the packed micro-op payload
// and small helper functions.
package legv8_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned WORD_W = 32;

  // Micro-op classes as presented on in_op; codes 10..15 are undefined.
  typedef enum logic [OP_W-1:0] {
    OP_ADDI = 4'd0,
    OP_ADDS = 4'd1,
    OP_SUBS = 4'd2,
    OP_B    = 4'd3,
    OP_B_LT = 4'd4,
    OP_BL   = 4'd5,
    OP_BR   = 4'd6,
    OP_CBZ  = 4'd7,
    OP_LDUR = 4'd8,
    OP_STUR = 4'd9
  } op_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_ILLEGAL = 2'd1,
    ERR_RANGE   = 2'd2,
    ERR_ADDR    = 2'd3
  } err_e;

  // Machine opcode fields, left-aligned at bit 31 of the instruction word.
  localparam logic [9:0]  MC_ADDI = 10'b1001000100;
  localparam logic [10:0] MC_ADDS = 11'b10101011000;
  localparam logic [10:0] MC_SUBS = 11'b11101011000;
  localparam logic [10:0] MC_LDUR = 11'b11111000010;
  localparam logic [10:0] MC_STUR = 11'b11111000000;
  localparam logic [10:0] MC_BR   = 11'b11010110000;
  localparam logic [5:0]  MC_B    = 6'b000101;
  localparam logic [5:0]  MC_BL   = 6'b100101;
  localparam logic [7:0]  MC_B_LT = 8'b01010100;
  localparam logic [7:0]  MC_CBZ  = 8'b10110100;
  localparam logic [3:0]  COND_LT = 4'b1011;

  // Legal immediate ranges (inclusive).
  localparam int IMM12_MIN = 0;
  localparam int IMM12_MAX = 4095;
  localparam int IMM26_MIN = -(2 ** 25);
  localparam int IMM26_MAX = (2 ** 25) - 1;
  localparam int IMM19_MIN = -(2 ** 18);
  localparam int IMM19_MAX = (2 ** 18) - 1;
  localparam int IMM9_MIN  = -256;
  localparam int IMM9_MAX  = 255;

  // One micro-op after branch-target resolution (imm is PC-relative).
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rn;
    logic [REG_W-1:0]  rm;
    logic [WORD_W-1:0] imm;
  } uop_t;

  // Ops whose immediate is a PC-relative word offset.
  function automatic logic is_pc_rel(input logic [OP_W-1:0] op);
    return (op == OP_B) || (op == OP_BL) || (op == OP_B_LT) || (op == OP_CBZ);
  endfunction

  function automatic logic in_range(input logic signed [WORD_W-1:0] v,
                                    input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/legv8_field_pack.sv
// Combinational packer: one resolved micro-op -> 32-bit LEGv8 word plus
// illegal-op and immediate-range flags.
// Ports:
//   i_uop           resolved micro-op (op, rd, rn, rm, PC-relative imm)
//   o_word_c        encoded instruction (unused fields are 0)
//   o_illegal_c     op code is not a defined op_e value
//   o_range_err_c   immediate does not fit its field
module legv8_field_pack
  import legv8_pkg::*;
(
  input  uop_t              i_uop,
  output logic [WORD_W-1:0] o_word_c,
  output logic              o_illegal_c,
  output logic              o_range_err_c
);

  logic signed [WORD_W-1:0] w_imm;
  assign w_imm = $signed(i_uop.imm);

  // Field placement and range check per op class.
  always_comb begin
    o_word_c      = '0;
    o_illegal_c   = 1'b0;
    o_range_err_c = 1'b0;
    case (i_uop.op)
      OP_ADDI: begin
        o_word_c      = {MC_ADDI, i_uop.imm[11:0], i_uop.rn, i_uop.rd};
        o_range_err_c = !in_range(w_imm, IMM12_MIN, IMM12_MAX);
      end
      OP_ADDS: o_word_c = {MC_ADDS, i_uop.rm, 6'd0, i_uop.rn, i_uop.rd};
      OP_SUBS: o_word_c = {MC_SUBS, i_uop.rm, 6'd0, i_uop.rn, i_uop.rd};
      OP_B: begin
        o_word_c      = {MC_B, i_uop.imm[25:0]};
        o_range_err_c = !in_range(w_imm, IMM26_MIN, IMM26_MAX);
      end
      OP_BL: begin
        o_word_c      = {MC_BL, i_uop.imm[25:0]};
        o_range_err_c = !in_range(w_imm, IMM26_MIN, IMM26_MAX);
      end
      OP_B_LT: begin
        o_word_c      = {MC_B_LT, i_uop.imm[18:0], 1'b0, COND_LT};
        o_range_err_c = !in_range(w_imm, IMM19_MIN, IMM19_MAX);
      end
      OP_CBZ: begin
        o_word_c      = {MC_CBZ, i_uop.imm[18:0], i_uop.rd};
        o_range_err_c = !in_range(w_imm, IMM19_MIN, IMM19_MAX);
      end
      OP_LDUR: begin
        o_word_c      = {MC_LDUR, i_uop.imm[8:0], 2'b00, i_uop.rn, i_uop.rd};
        o_range_err_c = !in_range(w_imm, IMM9_MIN, IMM9_MAX);
      end
      OP_STUR: begin
        o_word_c      = {MC_STUR, i_uop.imm[8:0], 2'b00, i_uop.rn, i_uop.rd};
        o_range_err_c = !in_range(w_imm, IMM9_MIN, IMM9_MAX);
      end
      OP_BR:   o_word_c = {MC_BR, 16'd0, i_uop.rd};
      default: o_illegal_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Streams LEGv8 micro-ops, encoded to machine words, into instruction
// memory at consecutive word addresses (self-test program loading).
// Ports:
//   clk, reset          clock; synchronous active-low reset
//   start, base_addr    begin a new image at base_addr (not while running)
//   in_valid/in_ready   micro-op handshake; in_ready is combinational
//   in_op, in_rd/rn/rm  op class and register fields
//   in_imm, in_abs      immediate; in_abs marks an absolute branch target
//   in_last             final op of the image
//   imem_we/addr/wdata  registered write port, one cycle after acceptance
//   count               words written since start
//   busy, done, err     status; done and err are sticky until start
//   err_code            0 none, 1 illegal op, 2 imm range, 3 address overflow
module instr_encoder
  import legv8_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [REG_W-1:0]  in_rn,
  input  logic [REG_W-1:0]  in_rm,
  input  logic [WORD_W-1:0] in_imm,
  input  logic              in_abs,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_ERR} state_e;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [ADDR_W-1:0]   r_base;
  logic [CNT_W-1:0]    r_count;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [WORD_W-1:0]   r_wdata;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  err_e                r_code;

  logic [CNT_W-1:0]    w_wa_ext;
  logic                w_addr_ovf;
  logic [WORD_W-1:0]   w_wa32;
  logic [WORD_W-1:0]   w_imm_res;
  uop_t                w_uop;
  logic [WORD_W-1:0]   w_word;
  logic                w_illegal;
  logic                w_range;
  err_e                w_code;
  logic                w_accept;
  logic                w_fault;
  logic                w_start_ok;

  // Write pointer kept one bit wide so a wrap past the top is visible.
  assign w_wa_ext   = CNT_W'(r_base) + r_count;
  assign w_addr_ovf = w_wa_ext[ADDR_W];
  assign w_wa32     = WORD_W'(w_wa_ext[ADDR_W-1:0]);

  // Absolute branch targets become offsets from this op's own address.
  assign w_imm_res = (in_abs && is_pc_rel(in_op)) ? (in_imm - w_wa32) : in_imm;
  assign w_uop     = {in_op, in_rd, in_rn, in_rm, w_imm_res};

  legv8_field_pack u_pack (
    .i_uop         (w_uop),
    .o_word_c      (w_word),
    .o_illegal_c   (w_illegal),
    .o_range_err_c (w_range)
  );

  // Error priority: illegal op, then immediate range, then address overflow.
  always_comb begin
    w_code = ERR_NONE;
    if (w_illegal)       w_code = ERR_ILLEGAL;
    else if (w_range)    w_code = ERR_RANGE;
    else if (w_addr_ovf) w_code = ERR_ADDR;
  end

  assign in_ready   = (r_state == S_RUN) && (w_code == ERR_NONE);
  assign w_accept   = in_valid && in_ready;
  assign w_fault    = (r_state == S_RUN) && in_valid && (w_code != ERR_NONE);
  assign w_start_ok = start && (r_state != S_RUN);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; an error outranks in_last in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = S_RUN;
      S_RUN: begin
        if (w_fault)                  w_state_nxt = S_ERR;
        else if (w_accept && in_last) w_state_nxt = S_DONE;
      end
      S_DONE, S_ERR: if (start) w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Pointer, counter, status and the write output stage.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_base  <= '0;
      r_count <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_code  <= ERR_NONE;
    end else begin
      r_we    <= w_accept;
      r_addr  <= w_accept ? w_wa_ext[ADDR_W-1:0] : '0;
      r_wdata <= w_accept ? w_word : '0;
      r_busy  <= (w_state_nxt == S_RUN) || w_accept;
      if (w_start_ok) begin
        r_base  <= base_addr;
        r_count <= '0;
        r_done  <= 1'b0;
        r_err   <= 1'b0;
        r_code  <= ERR_NONE;
      end else begin
        if (w_accept) r_count <= r_count + CNT_W'(1);
        if (w_accept && in_last) r_done <= 1'b1;
        if (w_fault) begin
          r_err  <= 1'b1;
          r_code <= w_code;
        end
      end
    end
  end

  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign count      = r_count;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign err_code   = r_code;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed cases plus randomized
// images compared against a cycle-level reference model.
module tb_instr_encoder;

  localparam int unsigned AW = 10;
  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2, M_ERR = 3;

  logic          clk = 1'b0;
  logic          reset, start, in_valid, in_ready, in_abs, in_last;
  logic [AW-1:0] base_addr, imem_addr;
  logic [3:0]    in_op;
  logic [4:0]    in_rd, in_rn, in_rm;
  logic [31:0]   in_imm, imem_wdata;
  logic          imem_we, busy, done, err;
  logic [AW:0]   count;
  logic [1:0]    err_code;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm), .in_imm(in_imm),
    .in_abs(in_abs), .in_last(in_last), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .count(count),
    .busy(busy), .done(done), .err(err), .err_code(err_code)
  );

  typedef struct {
    int          op;
    int          rd;
    int          rn;
    int          rm;
    logic [31:0] imm;
    bit          abs_f;
    bit          last;
  } tb_op_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  int          m_mode  = M_IDLE;
  int          m_count = 0;
  int          m_base  = 0;
  bit          e_we = 0, e_busy = 0, e_done = 0, e_err = 0;
  int          e_addr = 0, e_code = 0;
  logic [31:0] e_wdata = '0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic tb_op_t mk(input int op, input int rd, input int rn, input int rm,
                                input logic [31:0] imm, input bit abs_f, input bit last);
    tb_op_t o;
    o.op = op; o.rd = rd; o.rn = rn; o.rm = rm; o.imm = imm; o.abs_f = abs_f; o.last = last;
    return o;
  endfunction

  // Encoding from the instruction formats, using shifted opcode constants.
  function automatic void ref_enc(input tb_op_t o, input int wa,
                                  output logic [31:0] w, output int code);
    logic [31:0] off, rd, rn, rm;
    longint v;
    rd = 32'(o.rd); rn = 32'(o.rn); rm = 32'(o.rm);
    off = o.imm;
    if (o.abs_f && (o.op == 3 || o.op == 4 || o.op == 5 || o.op == 7)) off = o.imm - 32'(wa);
    v = longint'($signed(off));
    w = '0;
    code = 0;
    case (o.op)
      0: begin
        w = 32'h91000000 | ((off & 32'hFFF) << 10) | (rn << 5) | rd;
        if (v < 0 || v > 4095) code = 2;
      end
      1: w = 32'hAB000000 | (rm << 16) | (rn << 5) | rd;
      2: w = 32'hEB000000 | (rm << 16) | (rn << 5) | rd;
      3, 5: begin
        w = ((o.op == 3) ? 32'h14000000 : 32'h94000000) | (off & 32'h03FFFFFF);
        if (v < -(64'sd1 << 25) || v > (64'sd1 << 25) - 1) code = 2;
      end
      4, 7: begin
        w = ((o.op == 4) ? (32'h54000000 | 32'hB) : (32'hB4000000 | rd)) | ((off & 32'h7FFFF) << 5);
        if (v < -(64'sd1 << 18) || v > (64'sd1 << 18) - 1) code = 2;
      end
      6: w = 32'hD6000000 | rd;
      8, 9: begin
        w = ((o.op == 8) ? 32'hF8400000 : 32'hF8000000) | ((off & 32'h1FF) << 12) | (rn << 5) | rd;
        if (v < -256 || v > 255) code = 2;
      end
      default: code = 1;
    endcase
  endfunction

  // Random signed immediate for an n-bit field, biased toward the edges.
  function automatic logic [31:0] pick_s(input int n);
    int          sel;
    logic [31:0] mx, mn, t;
    sel = int'($urandom_range(0, 19));
    mx  = (32'd1 << (n - 1)) - 32'd1;
    mn  = ~mx;
    t   = $urandom;
    if (sel == 0) return mx;
    if (sel == 1) return mn;
    if (sel == 2) return mx + 32'd1;
    if (sel == 3) return mn - 32'd1;
    return 32'($signed(t << (32 - n)) >>> (32 - n));
  endfunction

  function automatic tb_op_t rand_op(input bit last);
    tb_op_t o;
    int     sel;
    o = mk(0, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
           int'($urandom_range(0, 31)), $urandom, ($urandom_range(0, 3) == 0), last);
    o.op = ($urandom_range(0, 99) < 4) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
    sel = int'($urandom_range(0, 19));
    case (o.op)
      0: o.imm = (sel == 0) ? 32'd4095 : (sel == 1) ? 32'd0 : (sel == 2) ? 32'd4096 :
                 (sel == 3) ? 32'hFFFFFFFF : 32'($urandom_range(0, 4095));
      3, 5: o.imm = pick_s(26);
      4, 7: o.imm = pick_s(19);
      8, 9: o.imm = pick_s(9);
      default: ;
    endcase
    if (o.abs_f && (o.op == 3 || o.op == 4 || o.op == 5 || o.op == 7))
      o.imm = o.imm + 32'(m_base + m_count);
    return o;
  endfunction

  // One clock: drive at negedge, predict, step the model at posedge, compare at negedge.
  task automatic cyc(input bit rst_v, input bit st, input int base, input bit v, input tb_op_t o);
    logic [31:0] w;
    int          code, wa;
    bit          rdy, acc;
    reset = rst_v; start = st; base_addr = base[AW-1:0]; in_valid = v;
    in_op = 4'(o.op); in_rd = 5'(o.rd); in_rn = 5'(o.rn); in_rm = 5'(o.rm);
    in_imm = o.imm; in_abs = o.abs_f; in_last = o.last;
    #1;
    wa = m_base + m_count;
    ref_enc(o, wa, w, code);
    if (code == 0 && wa >= (1 << AW)) code = 3;
    rdy = (m_mode == M_RUN) && (code == 0);
    if (v) chk_eq("in_ready", 64'(in_ready), 64'(rdy));
    acc = v && rdy;
    @(posedge clk);
    if (!rst_v) begin
      m_mode = M_IDLE; m_count = 0; m_base = 0;
      e_we = 0; e_addr = 0; e_wdata = '0; e_busy = 0; e_done = 0; e_err = 0; e_code = 0;
    end else begin
      e_we = acc;
      if (acc) begin
        e_addr = wa; e_wdata = w; m_count++;
      end
      if (m_mode == M_RUN) begin
        if (v && code != 0) begin
          m_mode = M_ERR; e_err = 1; e_code = code;
        end else if (acc && o.last) begin
          m_mode = M_DONE; e_done = 1;
        end
      end else if (st) begin
        m_mode = M_RUN; m_count = 0; m_base = base;
        e_done = 0; e_err = 0; e_code = 0;
      end
      e_busy = (m_mode == M_RUN) || acc;
    end
    @(negedge clk);
    chk_eq("imem_we", 64'(imem_we), 64'(e_we));
    if (e_we || !rst_v) begin
      chk_eq("imem_addr", 64'(imem_addr), 64'(e_addr));
      chk_eq("imem_wdata", 64'(imem_wdata), 64'(e_wdata));
    end
    chk_eq("count", 64'(count), 64'(m_count));
    chk_eq("busy", 64'(busy), 64'(e_busy));
    chk_eq("done", 64'(done), 64'(e_done));
    chk_eq("err", 64'(err), 64'(e_err));
    chk_eq("err_code", 64'(err_code), 64'(e_code));
  endtask

  tb_op_t nop;

  initial begin
    nop = mk(0, 0, 0, 0, '0, 0, 0);
    cyc(0, 0, 0, 0, nop);
    cyc(0, 0, 0, 0, nop);
    chk_eq("reset_we", 64'(imem_we), 64'd0);

    // Basic encodings from base 0.
    cyc(1, 1, 0, 0, nop);
    cyc(1, 0, 0, 1, mk(0, 1, 2, 0, 32'd5, 0, 0));
    chk_eq("addi_word", 64'(imem_wdata), 64'h91001441);
    cyc(1, 0, 0, 1, mk(1, 3, 1, 2, '0, 0, 0));
    chk_eq("adds_word", 64'(imem_wdata), 64'hAB020023);
    cyc(1, 0, 0, 1, mk(2, 3, 1, 2, '0, 0, 0));
    chk_eq("subs_word", 64'(imem_wdata), 64'hEB020023);
    chk_eq("subs_addr", 64'(imem_addr), 64'd2);
    cyc(1, 0, 0, 1, mk(3, 0, 0, 0, 32'hFFFFFFFF, 0, 0));
    chk_eq("b_word", 64'(imem_wdata), 64'h17FFFFFF);
    cyc(1, 0, 0, 1, mk(4, 0, 0, 0, 32'd2, 0, 0));
    chk_eq("blt_word", 64'(imem_wdata), 64'h5400004B);
    cyc(1, 0, 0, 1, mk(8, 0, 1, 0, 32'hFFFFFFF8, 0, 1));
    chk_eq("ldur_word", 64'(imem_wdata), 64'hF85F8020);
    cyc(1, 0, 0, 0, nop);
    chk_eq("done_sticky", 64'(done), 64'd1);

    // Absolute CBZ target resolved against its own address.
    cyc(1, 1, 'h10, 0, nop);
    cyc(1, 0, 0, 1, mk(0, 1, 1, 0, 32'd1, 0, 0));
    cyc(1, 0, 0, 1, mk(0, 1, 1, 0, 32'd2, 0, 0));
    cyc(1, 0, 0, 1, mk(7, 0, 0, 0, 32'h10, 1, 1));
    chk_eq("cbz_word", 64'(imem_wdata), 64'hB4FFFFC0);
    chk_eq("cbz_addr", 64'(imem_addr), 64'h12);

    // Range error, recovery via start.
    cyc(1, 1, 'h20, 0, nop);
    cyc(1, 0, 0, 1, mk(0, 1, 1, 0, 32'd4096, 0, 0));
    chk_eq("range_code", 64'(err_code), 64'd2);
    cyc(1, 1, 'h20, 0, nop);
    cyc(1, 0, 0, 1, mk(0, 4, 5, 0, 32'd7, 0, 1));
    chk_eq("recover_addr", 64'(imem_addr), 64'h20);

    // Address overflow at the top of memory.
    cyc(1, 1, (1 << AW) - 1, 0, nop);
    cyc(1, 0, 0, 1, mk(0, 1, 1, 0, 32'd1, 0, 0));
    cyc(1, 0, 0, 1, mk(0, 1, 1, 0, 32'd2, 0, 1));
    chk_eq("ovf_code", 64'(err_code), 64'd3);

    // Reset aborts a run and suppresses the write.
    cyc(1, 1, 0, 0, nop);
    cyc(1, 0, 0, 1, mk(0, 1, 1, 0, 32'd3, 0, 0));
    cyc(0, 0, 0, 1, mk(0, 1, 1, 0, 32'd4, 0, 0));
    chk_eq("rst_we", 64'(imem_we), 64'd0);

    // Randomized images.
    for (int img = 0; img < 15; img++) begin
      cyc(1, 1, int'($urandom_range(0, 'h300)), 0, nop);
      for (int k = 0; k < 24; k++) begin
        bit v;
        v = (k == 23) || ($urandom_range(0, 4) != 0);
        cyc(1, ($urandom_range(0, 19) == 0), int'($urandom_range(0, 'h300)), v, rand_op(k == 23));
      end
      cyc(1, 0, 0, 0, nop);
      cyc(1, 0, 0, 0, nop);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
